mult_sched_2p: RTL and testbench

Two-port scheduler for the shared shift-and-add multiplier datapath. Arbitrates round-robin between two requesters. Latches the winner's operands and sequences the shift/add iterations. Returns the product to the owning port with a one-cycle completion pulse. Sits between the slow-clock control domain (button/switch front ends, FSM clients) and the single multiplier datapath, so two clients share one datapath instance.

---
 rtl/mult_sched_pkg.sv | 16 +
 rtl/shift_add_dp.sv | 52 +++++
 rtl/mult_sched_2p.sv | 124 ++++++++++++
 tb/tb_mult_sched_2p.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// Shared definitions for the two-port multiplier scheduler: FSM states,
// default operand width and requester port indices.
package mult_sched_pkg;

    localparam int unsigned W_DEFAULT = 5;

    localparam int unsigned P0 = 0;
    localparam int unsigned P1 = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_dp.sv
// Shift-and-add multiplier datapath. Holds the multiplicand (2W, shifted
// left each step), the multiplier (W, shifted right each step), the
// accumulator and the iteration counter. The scheduler drives load/step.
module shift_add_dp
    import mult_sched_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] acc,
    output logic           mplier_zero,
    output logic           cnt_last
);

    localparam int unsigned CW = $clog2(W) + 1;

    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  cnt;

    // Status reflects the values the current step will leave behind
    assign mplier_zero = ((mplier >> 1) == '0);
    assign cnt_last    = (cnt == CW'(W - 1));

    // Operand capture on load, one add/shift iteration per step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= {{W{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mult_sched_2p.sv
// Two-port round-robin scheduler in front of one shift-and-add multiplier.
// Grants one requester at a time, runs the multiply, then returns the
// product with a one-cycle DONE pulse to the owning port.
// Optional: define MULT_SCHED_EARLY_EXIT_EN to leave RUN as soon as the
// remaining multiplier bits are all zero (same results, shorter latency).
module mult_sched_2p
    import mult_sched_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [1:0]     REQ,
    input  logic [W-1:0]   A0,
    input  logic [W-1:0]   B0,
    input  logic [W-1:0]   A1,
    input  logic [W-1:0]   B1,
    output logic [1:0]     GNT,
    output logic [1:0]     DONE,
    output logic [2*W-1:0] PROD,
    output logic           BUSY,
    output logic           OWNER
);

`ifdef MULT_SCHED_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    state_t         state;
    logic           last;
    logic           winner;
    logic           load;
    logic           step;
    logic           run_exit;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    logic [1:0]     gnt_vec;
    logic [1:0]     done_vec;
    logic [2*W-1:0] acc;
    logic           mplier_zero;
    logic           cnt_last;

    // Round-robin pick: a lone requester wins, a tie goes to the port != last
    always_comb begin
        winner = REQ[P1];
        if (REQ == 2'b11) begin
            winner = ~last;
        end
    end

    assign a_sel = winner ? A1 : A0;
    assign b_sel = winner ? B1 : B0;

    assign load     = (state == IDLE) && (REQ != 2'b00);
    assign step     = (state == RUN);
    assign run_exit = cnt_last | (EARLY_EXIT & mplier_zero);

    // One-hot pulse vectors for the granted and the finishing port
    always_comb begin
        gnt_vec          = '0;
        gnt_vec[winner]  = 1'b1;
        done_vec         = '0;
        done_vec[OWNER]  = 1'b1;
    end

    shift_add_dp #(
        .W (W)
    ) u_dp (
        .clk         (CLK),
        .rst         (RST),
        .load        (load),
        .step        (step),
        .a           (a_sel),
        .b           (b_sel),
        .acc         (acc),
        .mplier_zero (mplier_zero),
        .cnt_last    (cnt_last)
    );

    // Scheduler FSM with round-robin history and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            last  <= 1'b1;
            GNT   <= '0;
            DONE  <= '0;
            PROD  <= '0;
            BUSY  <= 1'b0;
            OWNER <= 1'b0;
        end else begin
            GNT  <= '0;
            DONE <= '0;
            case (state)
                IDLE: begin
                    BUSY <= 1'b0;
                    if (load) begin
                        GNT   <= gnt_vec;
                        OWNER <= winner;
                        last  <= winner;
                        BUSY  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (run_exit) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    // BUSY stays high through the DONE cycle and drops in IDLE
                    PROD  <= acc;
                    DONE  <= done_vec;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sched_2p.sv
// Self-checking bench for mult_sched_2p: directed scenarios plus randomized
// traffic checked against a behavioural model (a*b, round-robin rule,
// latency from the multiplier's highest set bit).
module tb_mult_sched_2p;

    localparam int W = 5;

    logic           CLK = 1'b0;
    logic           RST;
    logic [1:0]     REQ;
    logic [W-1:0]   A0, B0, A1, B1;
    logic [1:0]     GNT, DONE;
    logic [2*W-1:0] PROD;
    logic           BUSY, OWNER;

    int   tests_run    = 0;
    int   tests_failed = 0;
    logic ref_last;

    mult_sched_2p #(
        .W (W)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .REQ   (REQ),
        .A0    (A0),
        .B0    (B0),
        .A1    (A1),
        .B1    (B1),
        .GNT   (GNT),
        .DONE  (DONE),
        .PROD  (PROD),
        .BUSY  (BUSY),
        .OWNER (OWNER)
    );

    always #5 CLK = ~CLK;

    // Cycles from the GNT cycle to the DONE cycle
    function automatic int exp_lat(input logic [W-1:0] b);
        int r;
        r = W;
`ifdef MULT_SCHED_EARLY_EXIT_EN
        r = 1;
        for (int i = 0; i < W; i++) begin
            if (b[i]) r = i + 1;
        end
`endif
        return r + 1;
    endfunction

    function automatic logic [1:0] ref_grant(input logic [1:0] req, input logic last);
        if (req == 2'b11) return last ? 2'b01 : 2'b10;
        return req;
    endfunction

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
        int p;
        p = int'(a) * int'(b);
        return (2*W)'(p);
    endfunction

    task automatic do_reset();
        RST = 1'b1;
        REQ = 2'b00;
        A0 = '0; B0 = '0; A1 = '0; B1 = '0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        ref_last = 1'b1;
    endtask

    // Waits (bounded) for a grant; g stays 0 on timeout
    task automatic wait_gnt(output logic [1:0] g, output int cyc);
        g = '0;
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            if (GNT != 2'b00) begin
                g = GNT;
                cyc = i;
                break;
            end
        end
    endtask

    // Waits (bounded) for DONE; clean=0 if BUSY dropped or GNT fired meanwhile
    task automatic wait_done(output logic [1:0] d, output int lat,
                             output logic [2*W-1:0] p, output bit clean);
        d = '0;
        lat = 0;
        p = '0;
        clean = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge CLK);
            if (!BUSY || GNT != 2'b00) clean = 1'b0;
            if (DONE != 2'b00) begin
                d = DONE;
                lat = i;
                p = PROD;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [1:0] g, d;
        int c, lat;
        logic [2*W-1:0] p;
        bit clean;
        do_reset();
        tests_run++;
        if ({GNT, DONE, PROD, BUSY, OWNER} !== '0) begin
            tests_failed++;
            $display("FAIL reset_init: got gnt=%b done=%b prod=%0d busy=%b owner=%b expected all zero",
                     GNT, DONE, PROD, BUSY, OWNER);
        end
        REQ = 2'b10; A1 = 5'd3; B1 = 5'd5;
        wait_gnt(g, c);
        REQ = 2'b00;
        wait_done(d, lat, p, clean);
        tests_run++;
        if (p !== 10'd15 || d !== 2'b10) begin
            tests_failed++;
            $display("FAIL reset_preop: got prod=%0d done=%b expected prod=15 done=10", p, d);
        end
        REQ = 2'b10;
        wait_gnt(g, c);
        #2 RST = 1'b1;
        #1;
        tests_run++;
        if ({GNT, DONE, PROD, BUSY, OWNER} !== '0) begin
            tests_failed++;
            $display("FAIL reset_async: got gnt=%b done=%b prod=%0d busy=%b owner=%b expected all zero",
                     GNT, DONE, PROD, BUSY, OWNER);
        end
        @(negedge CLK);
        RST = 1'b0;
        REQ = 2'b00;
    endtask

    task automatic test_single();
        logic [1:0] g, d;
        int c, lat;
        logic [2*W-1:0] p;
        bit clean;
        do_reset();
        REQ = 2'b01; A0 = 5'd31; B0 = 5'd31;
        wait_gnt(g, c);
        REQ = 2'b00; A0 = 5'd2; B0 = 5'd7;
        tests_run++;
        if (g !== 2'b01 || BUSY !== 1'b1 || OWNER !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_gnt: got gnt=%b busy=%b owner=%b expected 01 1 0", g, BUSY, OWNER);
        end
        wait_done(d, lat, p, clean);
        tests_run++;
        if (d !== 2'b01 || p !== 10'd961) begin
            tests_failed++;
            $display("FAIL single_prod: got done=%b prod=%0d expected done=01 prod=961", d, p);
        end
        tests_run++;
        if (lat !== exp_lat(5'd31) || !clean) begin
            tests_failed++;
            $display("FAIL single_lat: got lat=%0d clean=%0d expected lat=%0d clean=1", lat, clean, exp_lat(5'd31));
        end
        @(negedge CLK);
        tests_run++;
        if (BUSY !== 1'b0 || DONE !== 2'b00 || PROD !== 10'd961) begin
            tests_failed++;
            $display("FAIL single_after: got busy=%b done=%b prod=%0d expected 0 00 961", BUSY, DONE, PROD);
        end
    endtask

    task automatic test_tie_fairness();
        logic [1:0] g, d, exp;
        int c, lat;
        logic [2*W-1:0] p;
        bit clean;
        do_reset();
        A0 = 5'd3; B0 = 5'd4; A1 = 5'd5; B1 = 5'd6;
        REQ = 2'b11;
        for (int k = 0; k < 3; k++) begin
            exp = ref_grant(REQ, ref_last);
            wait_gnt(g, c);
            tests_run++;
            if (g !== exp || (k > 0 && c !== 1)) begin
                tests_failed++;
                $display("FAIL tie_gnt%0d: got gnt=%b after %0d cycles expected gnt=%b", k, g, c, exp);
            end
            ref_last = exp[1];
            REQ[exp[1]] = 1'b0;
            wait_done(d, lat, p, clean);
            tests_run++;
            if (d !== exp || p !== (exp[1] ? 10'd30 : 10'd12)) begin
                tests_failed++;
                $display("FAIL tie_prod%0d: got done=%b prod=%0d expected done=%b prod=%0d",
                         k, d, p, exp, exp[1] ? 30 : 12);
            end
            if (k < 2) REQ[exp[1]] = 1'b1;
        end
        REQ = 2'b00;
    endtask

    task automatic test_late_request();
        logic [1:0] g, d;
        int c, lat;
        logic [2*W-1:0] p;
        bit clean;
        do_reset();
        REQ = 2'b01; A0 = 5'd5; B0 = 5'd5;
        wait_gnt(g, c);
        REQ = 2'b00;
        repeat (2) @(negedge CLK);
        REQ = 2'b10; A1 = 5'd7; B1 = 5'd9;
        wait_done(d, lat, p, clean);
        tests_run++;
        if (d !== 2'b01 || p !== 10'd25 || !clean || lat !== exp_lat(5'd5) - 2) begin
            tests_failed++;
            $display("FAIL late_first: got done=%b prod=%0d clean=%0d lat=%0d expected 01 25 1 %0d",
                     d, p, clean, lat, exp_lat(5'd5) - 2);
        end
        wait_gnt(g, c);
        REQ = 2'b00;
        tests_run++;
        if (g !== 2'b10 || c !== 1) begin
            tests_failed++;
            $display("FAIL late_gnt: got gnt=%b after %0d cycles expected 10 after 1", g, c);
        end
        wait_done(d, lat, p, clean);
        tests_run++;
        if (d !== 2'b10 || p !== 10'd63 || lat !== exp_lat(5'd9)) begin
            tests_failed++;
            $display("FAIL late_prod: got done=%b prod=%0d lat=%0d expected 10 63 %0d", d, p, lat, exp_lat(5'd9));
        end
    endtask

    task automatic test_abort();
        logic [1:0] g, d;
        int c, lat;
        logic [2*W-1:0] p;
        bit clean;
        bit seen;
        do_reset();
        REQ = 2'b01; A0 = 5'd10; B0 = 5'd10;
        wait_gnt(g, c);
        REQ = 2'b00;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        #1;
        tests_run++;
        if (BUSY !== 1'b0 || GNT !== 2'b00 || DONE !== 2'b00) begin
            tests_failed++;
            $display("FAIL abort_rst: got busy=%b gnt=%b done=%b expected 0 00 00", BUSY, GNT, DONE);
        end
        @(negedge CLK);
        RST = 1'b0;
        ref_last = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge CLK);
            if (DONE != 2'b00 || BUSY) seen = 1'b1;
        end
        tests_run++;
        if (seen) begin
            tests_failed++;
            $display("FAIL abort_nodone: got activity=1 expected 0");
        end
        REQ = 2'b01; A0 = 5'd2; B0 = 5'd3;
        wait_gnt(g, c);
        REQ = 2'b00;
        wait_done(d, lat, p, clean);
        tests_run++;
        if (g !== 2'b01 || d !== 2'b01 || p !== 10'd6) begin
            tests_failed++;
            $display("FAIL abort_fresh: got gnt=%b done=%b prod=%0d expected 01 01 6", g, d, p);
        end
    endtask

    task automatic test_early_exit();
        logic [1:0] g, d;
        int c, lat;
        logic [2*W-1:0] p;
        bit clean;
        logic [W-1:0] ta [2];
        logic [W-1:0] tb [2];
        ta[0] = 5'd9; tb[0] = 5'd1;
        ta[1] = 5'd0; tb[1] = 5'd0;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            REQ = 2'b01; A0 = ta[k]; B0 = tb[k];
            wait_gnt(g, c);
            REQ = 2'b00; A0 = 5'd31; B0 = 5'd31;
            wait_done(d, lat, p, clean);
            tests_run++;
            if (d !== 2'b01 || p !== ref_prod(ta[k], tb[k]) || lat !== exp_lat(tb[k])) begin
                tests_failed++;
                $display("FAIL early_exit%0d: got done=%b prod=%0d lat=%0d expected 01 %0d %0d",
                         k, d, p, lat, ref_prod(ta[k], tb[k]), exp_lat(tb[k]));
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] g, d, exp;
        int c, lat;
        logic [2*W-1:0] p;
        bit clean;
        logic w;
        logic [W-1:0] opa [2];
        logic [W-1:0] opb [2];
        do_reset();
        for (int n = 0; n < 40; n++) begin
            for (int q = 0; q < 2; q++) begin
                if (!REQ[q] && ($urandom_range(0, 1) == 1 || REQ == 2'b00)) begin
                    opa[q] = W'($urandom);
                    opb[q] = W'($urandom);
                    if (q == 0) begin A0 = opa[q]; B0 = opb[q]; end
                    else        begin A1 = opa[q]; B1 = opb[q]; end
                    REQ[q] = 1'b1;
                end
            end
            exp = ref_grant(REQ, ref_last);
            wait_gnt(g, c);
            w = exp[1];
            ref_last = w;
            REQ[w] = 1'b0;
            if (w) begin A1 = W'($urandom); B1 = W'($urandom); end
            else   begin A0 = W'($urandom); B0 = W'($urandom); end
            tests_run++;
            if (g !== exp || OWNER !== w) begin
                tests_failed++;
                $display("FAIL rand_gnt%0d: got gnt=%b owner=%b expected gnt=%b owner=%b", n, g, OWNER, exp, w);
            end
            wait_done(d, lat, p, clean);
            tests_run++;
            if (d !== exp || p !== ref_prod(opa[w], opb[w]) || lat !== exp_lat(opb[w]) || !clean) begin
                tests_failed++;
                $display("FAIL rand_done%0d: got done=%b prod=%0d lat=%0d clean=%0d expected %b %0d %0d 1",
                         n, d, p, lat, clean, exp, ref_prod(opa[w], opb[w]), exp_lat(opb[w]));
            end
        end
        REQ = 2'b00;
    endtask

    initial begin
        RST = 1'b1;
        REQ = 2'b00;
        A0 = '0; B0 = '0; A1 = '0; B1 = '0;
        ref_last = 1'b1;
        #12;
        test_reset();
        test_single();
        test_tie_fairness();
        test_late_request();
        test_abort();
        test_early_exit();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
